// File: rtl/cm_unsort.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cm_unsort -- inverse permutation for cm_sort.
//
// Takes a sorted data vector plus the index vector emitted by cm_sort and
// scatters each element back to the position it originally came from:
// o_data[i_idx[k]] = i_data[k]. The inputs are captured on accept, then
// scattered LANES elements per cycle. While scattering, the index vector is
// checked, and o_err reports any of these problems: an out-of-range code,
// the same position written twice, or a position never written.
//
// Ports:
//   i_clk   clock (single domain)
//   i_rst   synchronous active-high reset
//   i_vld   input vector valid
//   o_rdy   ready to accept an input vector (only in IDLE)
//   i_idx   DCNT x IDX_WIDTH, element k originally sat at position i_idx[k]
//   i_data  DCNT x DWIDTH, sorted data
//   o_vld   restored vector valid
//   i_rdy   downstream ready
//   o_data  DCNT x DWIDTH restored vector; unwritten positions read 0
//   o_err   index error for the presented vector; meaningful while o_vld=1
// -----------------------------------------------------------------------------
module cm_unsort #(
  parameter  int DCNT      = 8,
  parameter  int DWIDTH    = 16,
  parameter  int LANES     = 1,
  localparam int IDX_WIDTH = $clog2(DCNT)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_vld,
  output logic                             o_rdy,
  input  logic [DCNT-1:0][IDX_WIDTH-1:0]   i_idx,
  input  logic [DCNT-1:0][DWIDTH-1:0]      i_data,
  output logic                             o_vld,
  input  logic                             i_rdy,
  output logic [DCNT-1:0][DWIDTH-1:0]      o_data,
  output logic                             o_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAT,
    ST_OUT
  } state_e;

  // Number of scatter cycles and the counter that walks them.
  localparam int              N_STEPS  = (DCNT + LANES - 1) / LANES;
  localparam int              CNT_W    = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STEPS - 1);

  // DCNT widened by one bit so an index code can be range-checked without
  // the compare overflowing when DCNT is a power of two.
  localparam int                  IDX_WP1  = IDX_WIDTH + 1;
  localparam logic [IDX_WIDTH:0]  DCNT_X   = IDX_WP1'(DCNT);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q,   cnt_d;
  logic [DCNT-1:0][IDX_WIDTH-1:0]  idx_q,   idx_d;
  logic [DCNT-1:0][DWIDTH-1:0]     data_q,  data_d;
  logic [DCNT-1:0][DWIDTH-1:0]     out_q,   out_d;
  logic [DCNT-1:0]                 mask_q,  mask_d;
  logic                            err_q,   err_d;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case/if tree leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    out_d   = out_q;
    mask_d  = mask_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_vld) begin
          idx_d   = i_idx;
          data_d  = i_data;
          out_d   = '0;
          mask_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SCAT;
        end
      end

      ST_SCAT: begin
        // Lanes are walked in increasing k with blocking updates of mask_d,
        // so a duplicate within one cycle sees the earlier lane's mask bit
        // (flagging the error) and the highest k's write is the one kept.
        for (int l = 0; l < LANES; l++) begin
          int                   k;
          logic [IDX_WIDTH-1:0] kk;
          logic [IDX_WIDTH-1:0] pos;
          k   = int'(cnt_q) * LANES + l;
          kk  = '0;
          pos = '0;
          if (k < DCNT) begin
            kk  = IDX_WIDTH'(k);
            pos = idx_q[kk];
            if ({1'b0, pos} < DCNT_X) begin
              out_d[pos] = data_q[kk];
              if (mask_d[pos]) begin
                err_d = 1'b1;
              end
              mask_d[pos] = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        if (cnt_q == CNT_LAST) begin
          // Coverage is judged on the mask including this last cycle's writes.
          if (!(&mask_d)) begin
            err_d = 1'b1;
          end
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_OUT: begin
        if (i_rdy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the data buffers are deliberately reset here: o_data must read
      // 0 after reset and an aborted vector must leave nothing behind.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      out_q   <= out_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_rdy  = (state_q == ST_IDLE) && !i_rst;
  assign o_vld  = (state_q == ST_OUT);
  assign o_err  = o_vld && err_q;
  assign o_data = out_q;

endmodule

// File: tb/tb_cm_unsort.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cm_unsort -- self-checking bench for cm_unsort.
//
// Four instances share clock and reset:
//   u=0  DCNT=4  LANES=1  (N=4)
//   u=1  DCNT=4  LANES=2  (N=2)
//   u=2  DCNT=6  LANES=1  (N=6, IDX_WIDTH=3, codes 6/7 out of range)
//   u=3  DCNT=10 LANES=3  (N=4)
// A table of hand-computed vectors, hand-written backpressure and reset
// sequences, and randomized vectors checked against a counting model.
// -----------------------------------------------------------------------------
module tb_cm_unsort;

  typedef logic [9:0][15:0] vec_t;

  typedef struct {
    int   u;
    vec_t idx;
    vec_t data;
    vec_t exp;
    logic err;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance signals ----------------
  logic a_ivld, a_ordy, a_ovld, a_irdy, a_oerr;
  logic [3:0][1:0]  a_idx;
  logic [3:0][15:0] a_data, a_odata;
  logic b_ivld, b_ordy, b_ovld, b_irdy, b_oerr;
  logic [3:0][1:0]  b_idx;
  logic [3:0][15:0] b_data, b_odata;
  logic c_ivld, c_ordy, c_ovld, c_irdy, c_oerr;
  logic [5:0][2:0]  c_idx;
  logic [5:0][15:0] c_data, c_odata;
  logic d_ivld, d_ordy, d_ovld, d_irdy, d_oerr;
  logic [9:0][3:0]  d_idx;
  logic [9:0][15:0] d_data, d_odata;

  cm_unsort #(.DCNT(4), .DWIDTH(16), .LANES(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_vld(a_ivld), .o_rdy(a_ordy), .i_idx(a_idx),
    .i_data(a_data), .o_vld(a_ovld), .i_rdy(a_irdy), .o_data(a_odata), .o_err(a_oerr));
  cm_unsort #(.DCNT(4), .DWIDTH(16), .LANES(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_vld(b_ivld), .o_rdy(b_ordy), .i_idx(b_idx),
    .i_data(b_data), .o_vld(b_ovld), .i_rdy(b_irdy), .o_data(b_odata), .o_err(b_oerr));
  cm_unsort #(.DCNT(6), .DWIDTH(16), .LANES(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_vld(c_ivld), .o_rdy(c_ordy), .i_idx(c_idx),
    .i_data(c_data), .o_vld(c_ovld), .i_rdy(c_irdy), .o_data(c_odata), .o_err(c_oerr));
  cm_unsort #(.DCNT(10), .DWIDTH(16), .LANES(3)) u_d (
    .i_clk(clk), .i_rst(rst), .i_vld(d_ivld), .o_rdy(d_ordy), .i_idx(d_idx),
    .i_data(d_data), .o_vld(d_ovld), .i_rdy(d_irdy), .o_data(d_odata), .o_err(d_oerr));

  // ---------------- helpers ----------------
  function automatic int dcnt_of(input int u);
    case (u)
      0, 1:    return 4;
      2:       return 6;
      default: return 10;
    endcase
  endfunction

  function automatic int steps_of(input int u);
    case (u)
      0:       return 4;
      1:       return 2;
      2:       return 6;
      default: return 4;
    endcase
  endfunction

  function automatic vec_t v(input int e0 = 0, input int e1 = 0, input int e2 = 0,
                             input int e3 = 0, input int e4 = 0, input int e5 = 0,
                             input int e6 = 0, input int e7 = 0, input int e8 = 0,
                             input int e9 = 0);
    int   e[10];
    vec_t r;
    e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8, e9};
    for (int k = 0; k < 10; k++) r[k] = 16'(e[k]);
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int k = 0; k < 10; k++) r[k] = 16'($urandom_range(0, 65535));
    return r;
  endfunction

  task automatic drive(input int u, input logic vld, input vec_t idx, input vec_t data);
    case (u)
      0: begin a_ivld = vld; for (int k = 0; k < 4; k++) begin a_idx[k] = idx[k][1:0]; a_data[k] = data[k]; end end
      1: begin b_ivld = vld; for (int k = 0; k < 4; k++) begin b_idx[k] = idx[k][1:0]; b_data[k] = data[k]; end end
      2: begin c_ivld = vld; for (int k = 0; k < 6; k++) begin c_idx[k] = idx[k][2:0]; c_data[k] = data[k]; end end
      default: begin d_ivld = vld; for (int k = 0; k < 10; k++) begin d_idx[k] = idx[k][3:0]; d_data[k] = data[k]; end end
    endcase
  endtask

  task automatic set_irdy(input int u, input logic r);
    case (u)
      0: a_irdy = r;
      1: b_irdy = r;
      2: c_irdy = r;
      default: d_irdy = r;
    endcase
  endtask

  function automatic logic ordy_of(input int u);
    case (u)
      0: return a_ordy;
      1: return b_ordy;
      2: return c_ordy;
      default: return d_ordy;
    endcase
  endfunction

  function automatic logic ovld_of(input int u);
    case (u)
      0: return a_ovld;
      1: return b_ovld;
      2: return c_ovld;
      default: return d_ovld;
    endcase
  endfunction

  function automatic logic oerr_of(input int u);
    case (u)
      0: return a_oerr;
      1: return b_oerr;
      2: return c_oerr;
      default: return d_oerr;
    endcase
  endfunction

  function automatic vec_t odata_of(input int u);
    vec_t r;
    r = '0;
    case (u)
      0: for (int k = 0; k < 4; k++) r[k] = a_odata[k];
      1: for (int k = 0; k < 4; k++) r[k] = b_odata[k];
      2: for (int k = 0; k < 6; k++) r[k] = c_odata[k];
      default: for (int k = 0; k < 10; k++) r[k] = d_odata[k];
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: count how many elements land on each position. Any
  // out-of-range code, or any position hit other than exactly once, is an
  // error. Later elements overwrite earlier ones.
  function automatic void model(input int n, input vec_t idx, input vec_t data,
                                output vec_t exp, output logic err);
    int hits[10];
    exp = '0;
    err = 1'b0;
    for (int p = 0; p < 10; p++) hits[p] = 0;
    for (int k = 0; k < n; k++) begin
      int p;
      p = int'(idx[k]);
      if (p < n) begin
        exp[p] = data[k];
        hits[p]++;
      end else begin
        err = 1'b1;
      end
    end
    for (int p = 0; p < n; p++) if (hits[p] != 1) err = 1'b1;
  endfunction

  // One full transaction with i_rdy held high. Returns the vector seen while
  // o_vld was high, the edge count from accept to the first edge with o_vld
  // high, and the cycle stamp of the accept edge. Called at a negedge.
  task automatic run_vec(input int u, input vec_t idx, input vec_t data, input string name,
                         output vec_t got, output logic err, output int lat, output int acc);
    int w;
    w = 0;
    while (!ordy_of(u) && w < 100) begin @(negedge clk); w++; end
    check({name, "_rdy_wait"}, ordy_of(u), 1'b1);
    set_irdy(u, 1'b1);
    drive(u, 1'b1, idx, data);
    @(negedge clk);
    acc = cyc;
    // Scramble inputs after accept; they must have no effect.
    drive(u, 1'b0, rnd_vec(), rnd_vec());
    lat = 0;
    while (!ovld_of(u) && lat < 100) begin @(negedge clk); lat++; end
    lat++;
    got = odata_of(u);
    err = oerr_of(u);
    check({name, "_no_rdy_with_vld"}, ordy_of(u), 1'b0);
    @(negedge clk);
    check({name, "_vld_after_hs"}, ovld_of(u), 1'b0);
    check({name, "_rdy_after_hs"}, ordy_of(u), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  rec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t got, exp_v, idx, data;
    logic got_err, exp_err, seen;
    int   lat, acc, prev_acc;

    tbl[0]  = '{0, v(3,1,0,2), v(10,20,30,40), v(30,20,40,10), 1'b0};
    tbl[1]  = '{0, v(1,1,0,2), v(10,20,30,40), v(30,20,40,0), 1'b1};
    tbl[2]  = '{1, v(1,1,0,2), v(10,20,30,40), v(30,20,40,0), 1'b1};
    tbl[3]  = '{1, v(3,1,0,2), v(10,20,30,40), v(30,20,40,10), 1'b0};
    tbl[4]  = '{2, v(7,0,1,2,3,4), v(10,20,30,40,50,60), v(20,30,40,50,60,0), 1'b1};
    tbl[5]  = '{2, v(5,4,3,2,1,0), v(1,2,3,4,5,6), v(6,5,4,3,2,1), 1'b0};
    tbl[6]  = '{2, v(6,1,2,3,4,5), v(10,20,30,40,50,60), v(0,20,30,40,50,60), 1'b1};
    tbl[7]  = '{3, v(0,1,2,3,4,5,6,7,8,9), v(100,101,102,103,104,105,106,107,108,109),
                   v(100,101,102,103,104,105,106,107,108,109), 1'b0};
    tbl[8]  = '{3, v(1,0,1,3,4,5,6,7,8,9), v(11,12,13,14,15,16,17,18,19,20),
                   v(12,13,0,14,15,16,17,18,19,20), 1'b1};
    tbl[9]  = '{3, v(9,8,7,6,5,4,3,2,1,0), v(1,2,3,4,5,6,7,8,9,10),
                   v(10,9,8,7,6,5,4,3,2,1), 1'b0};
    tbl[10] = '{3, v(0,1,2,3,4,5,6,7,8,15), v(1,2,3,4,5,6,7,8,9,10),
                   v(1,2,3,4,5,6,7,8,9,0), 1'b1};
    tbl[11] = '{0, v(0,0,0,0), v(5,6,7,8), v(8,0,0,0), 1'b1};

    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      drive(u, 1'b0, '0, '0);
      set_irdy(u, 1'b1);
    end
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_ordy", a_ordy, 1'b0);
    check("rst_ovld", a_ovld, 1'b0);
    check("rst_oerr", a_oerr, 1'b0);
    check("rst_odata", odata_of(0), '0);
    rst = 1'b0;
    #1;
    check("rst_release_ordy", a_ordy, 1'b1);
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      run_vec(tbl[i].u, tbl[i].idx, tbl[i].data, nm, got, got_err, lat, acc);
      check({nm, "_data"}, got, tbl[i].exp);
      check({nm, "_err"}, got_err, tbl[i].err);
      check({nm, "_latency"}, lat, steps_of(tbl[i].u) + 1);
    end

    // Backpressure on u=0: output held for 10 cycles while new input offered.
    set_irdy(0, 1'b0);
    drive(0, 1'b1, v(3,1,0,2), v(10,20,30,40));
    @(negedge clk);
    drive(0, 1'b0, '0, '0);
    lat = 0;
    while (!a_ovld && lat < 100) begin @(negedge clk); lat++; end
    for (int c = 0; c < 10; c++) begin
      drive(0, 1'b1, v(0,1,2,3), v(1,2,3,4));
      #1;
      check($sformatf("bp%0d_ovld", c), a_ovld, 1'b1);
      check($sformatf("bp%0d_odata", c), odata_of(0), v(30,20,40,10));
      check($sformatf("bp%0d_oerr", c), a_oerr, 1'b0);
      check($sformatf("bp%0d_ordy", c), a_ordy, 1'b0);
      @(negedge clk);
    end
    drive(0, 1'b0, '0, '0);
    set_irdy(0, 1'b1);
    @(negedge clk);
    check("bp_vld_after_hs", a_ovld, 1'b0);
    check("bp_rdy_after_hs", a_ordy, 1'b1);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (a_ovld) seen = 1'b1; end
    check("bp_ignored_input_not_queued", seen, 1'b0);

    // Reset in the middle of a scatter on u=0.
    drive(0, 1'b1, v(3,1,0,2), v(10,20,30,40));
    @(negedge clk);
    drive(0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ordy_in_reset", a_ordy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ordy_after", a_ordy, 1'b1);
    check("midrst_odata_cleared", odata_of(0), '0);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (a_ovld) seen = 1'b1; end
    check("midrst_no_output", seen, 1'b0);
    run_vec(0, v(2,0,3,1), v(7,8,9,10), "midrst_next", got, got_err, lat, acc);
    check("midrst_next_data", got, v(8,10,7,9));
    check("midrst_next_err", got_err, 1'b0);

    // Round trip on u=3: sort random vectors in the bench, unsort in the DUT.
    prev_acc = 0;
    for (int t = 0; t < 50; t++) begin
      int orig[10];
      int perm[10];
      for (int k = 0; k < 10; k++) begin
        orig[k] = $urandom_range(0, 65535);
        perm[k] = k;
      end
      for (int i = 1; i < 10; i++) begin
        int key, j;
        key = perm[i];
        j = i - 1;
        while (j >= 0 && orig[perm[j]] > orig[key]) begin
          perm[j+1] = perm[j];
          j--;
        end
        perm[j+1] = key;
      end
      exp_v = '0;
      for (int k = 0; k < 10; k++) begin
        idx[k]   = 16'(perm[k]);
        data[k]  = 16'(orig[perm[k]]);
        exp_v[k] = 16'(orig[k]);
      end
      run_vec(3, idx, data, $sformatf("rt%0d", t), got, got_err, lat, acc);
      check($sformatf("rt%0d_data", t), got, exp_v);
      check($sformatf("rt%0d_err", t), got_err, 1'b0);
      if (t > 0) check($sformatf("rt%0d_spacing", t), acc - prev_acc, 6);
      prev_acc = acc;
    end

    // Random index vectors (valid permutations, corrupted ones, raw codes).
    for (int t = 0; t < 40; t++) begin
      int u, n, mode;
      int p[10];
      u = (t % 2 == 0) ? 2 : 3;
      n = dcnt_of(u);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 10; k++) p[k] = k;
      for (int i = n - 1; i > 0; i--) begin
        int j, tmp;
        j = $urandom_range(0, i);
        tmp = p[i]; p[i] = p[j]; p[j] = tmp;
      end
      if (mode == 1) p[$urandom_range(0, n - 1)] = $urandom_range(0, (u == 2) ? 7 : 15);
      if (mode == 2) for (int k = 0; k < n; k++) p[k] = $urandom_range(0, (u == 2) ? 7 : 15);
      idx = '0;
      data = rnd_vec();
      for (int k = 0; k < 10; k++) begin
        if (k < n) idx[k] = 16'(p[k]);
        else data[k] = '0;
      end
      model(n, idx, data, exp_v, exp_err);
      run_vec(u, idx, data, $sformatf("rnd%0d", t), got, got_err, lat, acc);
      check($sformatf("rnd%0d_data", t), got, exp_v);
      check($sformatf("rnd%0d_err", t), got_err, exp_err);
      check($sformatf("rnd%0d_latency", t), lat, steps_of(u) + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
